// File: rtl/pipelined_addsub_pkg.sv
// Shared arithmetic definitions for the K-means datapath: default widths,
// op encoding and signed range limits.
package kmeans_arith_pkg;

    localparam int DEFAULT_WIDTH = 32;
    localparam int DEFAULT_SEG   = 8;
    localparam int LIMIT_W       = 64;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // Most negative (neg=1) or most positive (neg=0) two's-complement value of
    // the given width, sign-extended to LIMIT_W bits.
    function automatic logic signed [LIMIT_W-1:0] signed_limit(input int width, input logic neg);
        logic signed [LIMIT_W-1:0] min_v;
        min_v = -(64'sd1 <<< (width - 1));
        return neg ? min_v : ~min_v;
    endfunction

endpackage

// File: rtl/pipelined_addsub_if.sv
// Operand/result valid-ready bundle for pipelined_addsub.
interface pipelined_addsub_if
    import kmeans_arith_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_cout;
    logic             out_ovf;

    modport slave (
        input  in_valid, in_a, in_b, in_sub, out_ready,
        output in_ready, out_valid, out_sum, out_cout, out_ovf
    );

    modport master (
        output in_valid, in_a, in_b, in_sub, out_ready,
        input  in_ready, out_valid, out_sum, out_cout, out_ovf
    );
endinterface

// File: rtl/pipelined_addsub_segment.sv
// Combinational SEG-bit slice adder; c_msb is the carry into the slice MSB,
// needed for signed overflow when this slice holds the word MSB.
module addsub_segment #(
    parameter int SEG = 8
) (
    input  logic [SEG-1:0] a,
    input  logic [SEG-1:0] b,
    input  logic           cin,
    output logic [SEG-1:0] sum,
    output logic           cout,
    output logic           c_msb
);
    logic [SEG:0] full;

    assign full  = {1'b0, a} + {1'b0, b} + {{SEG{1'b0}}, cin};
    assign sum   = full[SEG-1:0];
    assign cout  = full[SEG];
    assign c_msb = full[SEG-1] ^ a[SEG-1] ^ b[SEG-1];
endmodule

// File: rtl/pipelined_addsub.sv
// Pipelined add/subtract, one SEG-bit carry segment per stage, valid/ready on both sides.
// Optional clamp on signed overflow: define PIPELINED_ADDSUB_SATURATE_EN.
module pipelined_addsub
    import kmeans_arith_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int SEG   = DEFAULT_SEG
) (
    input logic clk,
    input logic rst_n,
    pipelined_addsub_if.slave io
);
    localparam int STAGES = WIDTH / SEG;
    localparam int L      = STAGES - 1;

`ifdef PIPELINED_ADDSUB_SATURATE_EN
    localparam logic signed [WIDTH-1:0] SAT_MAX = WIDTH'(signed_limit(WIDTH, 1'b0));
    localparam logic signed [WIDTH-1:0] SAT_MIN = WIDTH'(signed_limit(WIDTH, 1'b1));
`endif

    logic [SEG-1:0]   seg_a    [STAGES];
    logic [SEG-1:0]   seg_b    [STAGES];
    logic [SEG-1:0]   seg_sum  [STAGES];
    logic             seg_cin  [STAGES];
    logic             seg_cout [STAGES];
    logic             seg_cmsb [STAGES];

    logic [WIDTH-1:0] a_d   [STAGES];
    logic [WIDTH-1:0] a_q   [STAGES];
    logic [WIDTH-1:0] b_d   [STAGES];
    logic [WIDTH-1:0] b_q   [STAGES];
    logic [WIDTH-1:0] s_d   [STAGES];
    logic [WIDTH-1:0] s_q   [STAGES];
    logic             c_d   [STAGES];
    logic             c_q   [STAGES];
    logic             ovf_d [STAGES];
    logic             ovf_q [STAGES];
    logic             vld_d [STAGES];
    logic             vld_q [STAGES];

    logic             stall;
    logic             in_fire;
    logic [WIDTH-1:0] b_eff;

    assign stall        = vld_q[L] && !io.out_ready;
    assign io.in_ready  = !stall;
    assign in_fire      = io.in_valid && !stall;
    assign b_eff        = (io.in_sub == OP_SUB) ? ~io.in_b : io.in_b;

    assign io.out_valid = vld_q[L];
    assign io.out_sum   = s_q[L];
    assign io.out_cout  = c_q[L];
    assign io.out_ovf   = ovf_q[L];

    // Stage k adds slice k of the skewed operands with the carry registered by stage k-1
    for (genvar k = 0; k < STAGES; k++) begin : g_seg
        if (k == 0) begin : g_first
            assign seg_a[k]   = io.in_a[SEG-1:0];
            assign seg_b[k]   = b_eff[SEG-1:0];
            assign seg_cin[k] = io.in_sub;
        end else begin : g_rest
            assign seg_a[k]   = a_q[k-1][k*SEG +: SEG];
            assign seg_b[k]   = b_q[k-1][k*SEG +: SEG];
            assign seg_cin[k] = c_q[k-1];
        end

        addsub_segment #(.SEG(SEG)) u_seg (
            .a     (seg_a[k]),
            .b     (seg_b[k]),
            .cin   (seg_cin[k]),
            .sum   (seg_sum[k]),
            .cout  (seg_cout[k]),
            .c_msb (seg_cmsb[k])
        );
    end

    always_comb begin
        a_d[0]   = io.in_a;
        b_d[0]   = b_eff;
        s_d[0]   = '0;
        vld_d[0] = in_fire;
        for (int k = 1; k < STAGES; k++) begin
            a_d[k]   = a_q[k-1];
            b_d[k]   = b_q[k-1];
            s_d[k]   = s_q[k-1];
            vld_d[k] = vld_q[k-1];
        end
        for (int k = 0; k < STAGES; k++) begin
            s_d[k][k*SEG +: SEG] = seg_sum[k];
            c_d[k]               = seg_cout[k];
            ovf_d[k]             = seg_cout[k] ^ seg_cmsb[k];
        end
`ifdef PIPELINED_ADDSUB_SATURATE_EN
        // On overflow both operands share the sign of A, which is the true result's sign
        if (ovf_d[L]) begin
            s_d[L] = seg_a[L][SEG-1] ? SAT_MIN : SAT_MAX;
        end
`endif
    end

    // Stage boundary: every register advances together unless the output is stalled
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < STAGES; k++) begin
                vld_q[k] <= 1'b0;
            end
            s_q[L]   <= '0;
            c_q[L]   <= 1'b0;
            ovf_q[L] <= 1'b0;
        end else if (!stall) begin
            for (int k = 0; k < STAGES; k++) begin
                vld_q[k] <= vld_d[k];
                a_q[k]   <= a_d[k];
                b_q[k]   <= b_d[k];
                s_q[k]   <= s_d[k];
                c_q[k]   <= c_d[k];
                ovf_q[k] <= ovf_d[k];
            end
        end
    end
endmodule

// File: tb/tb_pipelined_addsub.sv
// Self-checking bench for pipelined_addsub: directed vectors plus a queue-based model.
module tb_pipelined_addsub;
    typedef struct {
        logic [63:0] sum;
        logic        cout;
        logic        ovf;
    } res_t;

    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;
    res_t q[$];

    always #5 clk = ~clk;

    pipelined_addsub_if #(.WIDTH(32)) ifa ();
    pipelined_addsub_if #(.WIDTH(16)) ifb ();

    pipelined_addsub #(.WIDTH(32), .SEG(8))  dut32 (.clk(clk), .rst_n(rst_n), .io(ifa));
    pipelined_addsub #(.WIDTH(16), .SEG(16)) dut16 (.clk(clk), .rst_n(rst_n), .io(ifb));

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Reference: true signed result compared against the representable range.
    function automatic res_t model(input int w, input logic [63:0] a, input logic [63:0] b,
                                   input logic sub);
        res_t        r;
        logic [63:0] mask;
        logic [63:0] full;
        longint      sa, sb, t, mx, mn;
        mask   = (64'd1 << w) - 64'd1;
        full   = (a & mask) + (sub ? (~b & mask) : (b & mask)) + {63'd0, sub};
        sa     = $signed(a << (64 - w)) >>> (64 - w);
        sb     = $signed(b << (64 - w)) >>> (64 - w);
        t      = sub ? sa - sb : sa + sb;
        mx     = (64'sd1 <<< (w - 1)) - 1;
        mn     = -mx - 1;
        r.sum  = full & mask;
        r.cout = full[w];
        r.ovf  = (t > mx) || (t < mn);
`ifdef PIPELINED_ADDSUB_SATURATE_EN
        if (r.ovf) r.sum = (t > 0 ? mx : mn) & mask;
`endif
        return r;
    endfunction

    // Compare process for the 32-bit unit
    always @(negedge clk) begin
        res_t e;
        if (!rst_n) begin
            q.delete();
        end else begin
            chk("in_ready", ifa.in_ready, !(ifa.out_valid && !ifa.out_ready));
            if (q.size() == 0) begin
                chk("no_stale_out", ifa.out_valid, 1'b0);
            end else if (ifa.out_valid) begin
                e = q[0];
                chk("stream_sum",  ifa.out_sum,  e.sum);
                chk("stream_cout", ifa.out_cout, e.cout);
                chk("stream_ovf",  ifa.out_ovf,  e.ovf);
                if (ifa.out_ready) void'(q.pop_front());
            end
            if (ifa.in_valid && ifa.in_ready)
                q.push_back(model(32, {32'd0, ifa.in_a}, {32'd0, ifa.in_b}, ifa.in_sub));
        end
    end

    task automatic directed(input int sel, input logic [31:0] a, input logic [31:0] b,
                            input logic sub, input logic [31:0] es, input logic ec,
                            input logic eo, input int elat, input string nm);
        int   n = 0;
        int   w;
        res_t r;
        w = (sel == 0) ? 32 : 16;
        if (sel == 0) begin
            ifa.in_a = a; ifa.in_b = b; ifa.in_sub = sub; ifa.out_ready = 1'b1; ifa.in_valid = 1'b1;
        end else begin
            ifb.in_a = a[15:0]; ifb.in_b = b[15:0]; ifb.in_sub = sub; ifb.out_ready = 1'b1;
            ifb.in_valid = 1'b1;
        end
        for (int i = 1; i <= 10; i++) begin
            @(posedge clk);
            #1;
            if (i == 1) begin
                ifa.in_valid = 1'b0;
                ifb.in_valid = 1'b0;
            end
            if ((sel == 0 && ifa.out_valid) || (sel == 1 && ifb.out_valid)) begin
                n = i;
                break;
            end
        end
        chk({nm, "_latency"}, n, elat);
        if (sel == 0) begin
            chk({nm, "_sum"},  ifa.out_sum,  es);
            chk({nm, "_cout"}, ifa.out_cout, ec);
            chk({nm, "_ovf"},  ifa.out_ovf,  eo);
        end else begin
            chk({nm, "_sum"},  ifb.out_sum,  es);
            chk({nm, "_cout"}, ifb.out_cout, ec);
            chk({nm, "_ovf"},  ifb.out_ovf,  eo);
        end
        r = model(w, {32'd0, a}, {32'd0, b}, sub);
        chk({nm, "_model_sum"}, r.sum, {32'd0, es});
        chk({nm, "_model_ovf"}, r.ovf, eo);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] ra [20];
        logic [31:0] rb [20];
        logic        rs [20];
        int          idx;
        logic        took;

        rst_n = 1'b0;
        ifa.in_valid = 1'b0; ifa.in_a = '0; ifa.in_b = '0; ifa.in_sub = 1'b0; ifa.out_ready = 1'b1;
        ifb.in_valid = 1'b0; ifb.in_a = '0; ifb.in_b = '0; ifb.in_sub = 1'b0; ifb.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        chk("rst_out_valid", ifa.out_valid, 1'b0);
        chk("rst_out_sum",   ifa.out_sum,   32'd0);
        chk("rst_out_cout",  ifa.out_cout,  1'b0);
        chk("rst_out_ovf",   ifa.out_ovf,   1'b0);
        chk("rst_in_ready",  ifa.in_ready,  1'b1);
        chk("rst16_valid",   ifb.out_valid, 1'b0);

        directed(0, 32'h0000_00FF, 32'h0000_0001, 1'b0, 32'h0000_0100, 1'b0, 1'b0, 4, "add_ff_1");
        directed(0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 4, "add_wrap");
`ifdef PIPELINED_ADDSUB_SATURATE_EN
        directed(0, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h7FFF_FFFF, 1'b0, 1'b1, 4, "add_ovf");
        directed(0, 32'h8000_0000, 32'h0000_0001, 1'b1, 32'h8000_0000, 1'b1, 1'b1, 4, "sub_ovf");
`else
        directed(0, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 4, "add_ovf");
        directed(0, 32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 4, "sub_ovf");
`endif
        directed(0, 32'd5, 32'd7, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 4, "sub_5_7");
        directed(0, 32'd7, 32'd5, 1'b1, 32'h0000_0002, 1'b1, 1'b0, 4, "sub_7_5");

        // Back-to-back stream under a 1,0,0,1 out_ready pattern
        for (int i = 0; i < 20; i++) begin
            ra[i] = $urandom;
            rb[i] = $urandom;
            rs[i] = 1'($urandom_range(0, 1));
        end
        ra[3] = 32'h7FFF_FFFF; rb[3] = 32'h7FFF_FFFF; rs[3] = 1'b0;
        ra[7] = 32'h8000_0000; rb[7] = 32'h7FFF_FFFF; rs[7] = 1'b1;
        idx = 0;
        for (int cyc = 0; cyc < 400 && idx < 20; cyc++) begin
            ifa.out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
            ifa.in_valid  = 1'b1;
            ifa.in_a      = ra[idx];
            ifa.in_b      = rb[idx];
            ifa.in_sub    = rs[idx];
            @(negedge clk);
            took = ifa.in_ready;
            @(posedge clk);
            #1;
            if (took) idx++;
        end
        ifa.in_valid = 1'b0;
        chk("stream_accepted", idx, 20);
        for (int cyc = 0; cyc < 100; cyc++) begin
            ifa.out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
            @(posedge clk);
            #1;
            if (q.size() == 0 && !ifa.out_valid) break;
        end
        ifa.out_ready = 1'b1;
        chk("stream_drained", q.size(), 0);

        // Three beats in flight, then a one-cycle reset
        for (int i = 0; i < 3; i++) begin
            ifa.in_valid = 1'b1;
            ifa.in_a     = 32'd100 + 32'(i);
            ifa.in_b     = 32'd1;
            ifa.in_sub   = 1'b0;
            @(posedge clk);
            #1;
        end
        ifa.in_valid = 1'b0;
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        chk("flush_out_valid", ifa.out_valid, 1'b0);
        repeat (6) @(posedge clk);
        #1;
        directed(0, 32'h0000_1234, 32'h0000_0F0F, 1'b0, 32'h0000_2143, 1'b0, 1'b0, 4, "post_rst");

`ifdef PIPELINED_ADDSUB_SATURATE_EN
        directed(1, 32'h0000_8000, 32'h0000_8000, 1'b0, 32'h0000_8000, 1'b1, 1'b1, 1, "w16_ovf");
`else
        directed(1, 32'h0000_8000, 32'h0000_8000, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 1, "w16_ovf");
`endif
        directed(1, 32'h0000_0003, 32'h0000_0005, 1'b1, 32'h0000_FFFE, 1'b0, 1'b0, 1, "w16_sub");

        repeat (3) @(posedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/pipelined_addsub.md
Name: pipelined_addsub

Overview:
- Parametrised, pipelined add/subtract unit; successor to the fixed 32-bit combinational ripple adder.
- Splits the carry chain into registered SEG-bit segments, so long datapaths close timing.
- Moves operands over a valid/ready handshake with backpressure.
- Used by the K-means datapath for distance differences and centroid sum accumulation.

Parameters:
- WIDTH, 32, operand and result width in bits; must be a multiple of SEG.
- SEG, 8, bits resolved per pipeline stage; STAGES = WIDTH/SEG (1..8 supported).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous, active-low reset
- in_valid  in  1  operand beat valid
- in_ready  out  1  unit can accept a beat this cycle
- in_a  in  WIDTH  operand A
- in_b  in  WIDTH  operand B
- in_sub  in  1  0: A+B, 1: A-B
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts the result
- out_sum  out  WIDTH  result
- out_cout  out  1  unsigned carry out (for sub: 1 = no borrow)
- out_ovf  out  1  two's-complement signed overflow

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is synchronous and active-low.
- Reset values: every stage valid bit = 0, out_valid = 0, out_sum = 0, out_cout = 0, out_ovf = 0. in_ready = 1 in the first cycle after rst_n releases.
- Reset mid-operation: all in-flight beats are discarded. No result for those beats ever appears.
- Arithmetic: effective B = in_sub ? ~in_b : in_b; carry-in = in_sub.
- Stage k (0..STAGES-1):
  - adds slice [k*SEG +: SEG] of A and effective B, plus the registered carry from stage k-1 (stage 0 uses the carry-in);
  - registers that sum slice and the carry out.
- Skew: upper operand slices are carried forward unchanged through the earlier stage registers. Lower sum slices are carried forward to the output register.
- Flags:
  - out_cout = carry out of the MSB.
  - out_ovf = carry into the MSB XOR carry out of the MSB.
- Latency: a beat accepted in cycle t gives out_valid in cycle t+STAGES when there is no stall.
- Throughput: one beat per cycle.
- Handshake:
  - Input transfer when in_valid && in_ready. Output transfer when out_valid && out_ready.
  - stall = out_valid && !out_ready. While stall is high, every pipeline register holds its value.
  - in_ready = !stall (combinational).
  - Bubbles (valid = 0) propagate normally and are not compressed.
  - out_sum, out_cout and out_ovf hold stable while out_valid && !out_ready.
  - A simultaneous accept and emit in the same unstalled cycle is legal and must not lose a beat.
- Wrap-around: the result is modulo 2^WIDTH. 0xFFFFFFFF + 1 gives 0 with cout = 1.

Optional Feature:
- Macro: PIPELINED_ADDSUB_SATURATE_EN.
- Defined:
  - on signed overflow, out_sum clamps to the max positive value (0x7FFF_FFFF at WIDTH = 32) when the true result is positive, else to the min negative value (0x8000_0000);
  - out_ovf is still reported;
  - the clamp is applied in the final stage, so latency is unchanged.
- Undefined: the result wraps, and no clamp logic is synthesised.

Decomposition:
- Package kmeans_arith_pkg holds:
  - DEFAULT_WIDTH = 32 and DEFAULT_SEG = 8;
  - the op encoding constants OP_ADD = 1'b0 and OP_SUB = 1'b1;
  - a function returning the signed max/min value for a given width.
- One sub-module, addsub_segment: a combinational SEG-bit slice adder with carry-in, carry-out and carry into its MSB. It is instantiated STAGES times by generate.
- The stage registers live in the parent.

Test Plan:
- Config WIDTH = 32, SEG = 8, out_ready = 1. Drive 0x0000_00FF + 0x0000_0001 → after exactly 4 cycles: sum 0x0000_0100, cout 0, ovf 0.
- Drive 0xFFFF_FFFF + 0x0000_0001 → sum 0x0000_0000, cout 1, ovf 0. Then drive 0x7FFF_FFFF + 1 → sum 0x8000_0000 (0x7FFF_FFFF with SATURATE_EN), ovf 1.
- Subtract: 5 - 7 → sum 0xFFFF_FFFE, cout 0. Then 7 - 5 → sum 0x0000_0002, cout 1. Then 0x8000_0000 - 1 → ovf 1.
- Back-to-back stream of 20 random beats, with out_ready toggling 1,0,0,1 → results emerge in order, match the reference model, and hold stable during stalls. in_ready equals !stall every cycle.
- Load 3 beats, then pull rst_n low for 1 cycle → out_valid = 0 next cycle and no stale result ever appears. A new beat after reset returns after 4 cycles.
- Config WIDTH = 16, SEG = 16 (STAGES = 1): 0x8000 + 0x8000 → 1-cycle latency, sum 0x0000, cout 1, ovf 1.
